// File: rtl/candy_if_pkg.sv
// Shared types and helpers for the candy_if instruction-fetch stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package candy_if_pkg;

  // Depth of the fetch-to-decode queue
  localparam int IF_BUF_DEPTH = 2;

  // Fetch FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } if_state_t;

  // A new request may start only if the queue will still have a free slot
  // when the response returns, which holds whenever occupancy is at most 1.
  function automatic logic may_issue(input logic [1:0] cnt_after);
    return (cnt_after <= 2'd1);
  endfunction

endpackage

// File: rtl/candy_if_buf.sv
// Two-entry FIFO of {pc, inst} between instruction fetch and decode.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: head held stable until popped; clear empties it at the edge.
module candy_if_buf
  import candy_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [INST_W-1:0] push_inst,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  logic [ADDR_W-1:0] pc_mem   [IF_BUF_DEPTH];
  logic [INST_W-1:0] inst_mem [IF_BUF_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Clear wins over both push and pop; popping an empty queue is ignored.
  assign do_push = push & ~clear;
  assign do_pop  = pop & (count != 2'd0) & ~clear;

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (clear) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // Entry storage; reset to zero so the head reads 0 out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IF_BUF_DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (do_push) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

endmodule

// File: rtl/candy_if.sv
// Instruction fetch: issues SRAM reads at the current PC and queues results for decode.
// Latency: zero-wait ack gives 1 fetch/cycle; data reaches id_* the cycle after ack.
// Backpressure: stops requesting when the 2-entry queue would fill; flush drops in-flight data.
module candy_if
  import candy_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_enable_o,
  output logic              sram_req_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic              sram_ack_i,
  input  logic [INST_W-1:0] sram_rdata_i,
  input  logic              flush_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  if_state_t         state;
  logic              sram_req_q;
  logic [ADDR_W-1:0] held_addr;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              accept;
  logic              pop;

  // A response is kept only when it answers a live REQ and no redirect is in progress.
  assign accept = (state == S_REQ) & sram_ack_i & ~flush_i;

  // Decode handshake is ignored during a flush since the queue is being cleared.
  assign pop = id_valid_o & id_ready_i & ~flush_i;

  // Queue occupancy as it will be after this edge
  assign count_next = flush_i ? 2'd0 : (count + 2'(accept) - 2'(pop));

  // PC advances exactly once per instruction pushed; never during flush.
  assign pc_enable_o = accept;
  assign sram_req_o  = sram_req_q;

  // PC is stable in REQ because it only moves on ack. In DISCARD the PC has
  // already been redirected, so the stale request keeps its original address.
  assign sram_addr_o = (state == S_DISCARD) ? held_addr : pc_i;

  assign id_valid_o = (count != 2'd0);

  candy_if_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (accept),
    .push_pc   (pc_i),
    .push_inst (sram_rdata_i),
    .pop       (pop),
    .count     (count),
    .head_pc   (id_pc_o),
    .head_inst (id_inst_o)
  );

  // Fetch FSM with registered request output and held-address capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      sram_req_q <= 1'b0;
      held_addr  <= '0;
    end else begin
      if (state == S_REQ) held_addr <= pc_i;
      case (state)
        S_IDLE: begin
          // A flush seen while idle costs one extra idle cycle before refetching.
          if (!flush_i && may_issue(count_next)) begin
            state      <= S_REQ;
            sram_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (sram_ack_i) begin
            // Flush forces count_next to 0, so a flushed ack always refetches.
            if (may_issue(count_next)) begin
              state      <= S_REQ;
              sram_req_q <= 1'b1;
            end else begin
              state      <= S_IDLE;
              sram_req_q <= 1'b0;
            end
          end else if (flush_i) begin
            // Request cannot be withdrawn; wait for it and drop its data.
            state      <= S_DISCARD;
            sram_req_q <= 1'b1;
          end
        end
        S_DISCARD: begin
          if (sram_ack_i) begin
            state      <= S_REQ;
            sram_req_q <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          sram_req_q <= 1'b0;
        end
      endcase
    end
  end

  // A returning ack must always find a free slot in the queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(accept && !pop && count == 2'd2));

  // A request stays up until it is acknowledged.
  a_req_held: assert property (@(posedge clk) disable iff (!rst)
    (sram_req_o && !sram_ack_i) |=> sram_req_o);

endmodule

// File: tb/tb_candy_if.sv
// Scoreboard bench for candy_if with candy_pc and instruction SRAM models.
// Latency: checks 1-cycle ack-to-decode, delayed acks, flush and reset timing.
// Backpressure: exercises a stalled decoder filling the 2-entry queue.
module tb_candy_if;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic [31:0] pc_q;
  logic        pc_enable;
  logic        sram_req;
  logic [31:0] sram_addr;
  logic        sram_ack;
  logic [31:0] sram_rdata;
  logic        flush;
  logic [31:0] redirect;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int ack_delay;
  int ack_budget;
  int acks_done;
  int wait_cnt;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  candy_if #(
    .ADDR_W (32),
    .INST_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_q),
    .pc_enable_o  (pc_enable),
    .sram_req_o   (sram_req),
    .sram_addr_o  (sram_addr),
    .sram_ack_i   (sram_ack),
    .sram_rdata_i (sram_rdata),
    .flush_i      (flush),
    .id_valid_o   (id_valid),
    .id_ready_i   (id_ready),
    .id_pc_o      (id_pc),
    .id_inst_o    (id_inst)
  );

  // candy_pc model: reset to 0, reload on redirect, +4 on pc_enable
  always @(posedge clk or negedge rst) begin
    if (!rst)           pc_q <= 32'h0;
    else if (flush)     pc_q <= redirect;
    else if (pc_enable) pc_q <= pc_q + 32'd4;
  end

  // SRAM model: acks after ack_delay wait cycles, at most ack_budget acks since reset
  assign sram_rdata = 32'hA000_0000 | sram_addr;
  assign sram_ack   = sram_req && (wait_cnt >= ack_delay) && (acks_done < ack_budget);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 0;
      acks_done <= 0;
    end else if (sram_ack) begin
      wait_cnt  <= 0;
      acks_done <= acks_done + 1;
    end else if (sram_req) begin
      wait_cnt  <= wait_cnt + 1;
    end else begin
      wait_cnt  <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = 32'hA000_0000 | pc;
    exp_q.push_back(e);
  endtask

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_pt();
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, configure the models, release on a falling edge
  task automatic apply_reset(input int delay, input int budget, input logic ready);
    @(posedge clk);
    #1 rst = 1'b0;
    flush      = 1'b0;
    ack_delay  = delay;
    ack_budget = budget;
    id_ready   = ready;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_left"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  // Monitor: every decode handshake is compared against the scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_id: got pc 0x%08h inst 0x%08h, scoreboard empty", id_pc, id_inst);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_inst", id_inst, e.inst);
        end
      end
    end
  end

  initial begin
    flush      = 1'b0;
    redirect   = 32'h0;
    id_ready   = 1'b1;
    ack_delay  = 0;
    ack_budget = 6;
    #1 rst = 1'b0;

    // Reset state
    #21;
    chk("rst_req",      32'(sram_req),  32'h0);
    chk("rst_pc_en",    32'(pc_enable), 32'h0);
    chk("rst_id_valid", 32'(id_valid),  32'h0);
    chk("rst_id_pc",    id_pc,          32'h0);
    chk("rst_id_inst",  id_inst,        32'h0);
    #3 rst = 1'b1;

    // Zero-wait streaming with a ready decoder
    for (int i = 0; i < 6; i++) exp_push(32'(4 * i));
    drive_pt();
    for (int i = 0; i < 6; i++) begin
      sample_pt();
      chk("p1_req",   32'(sram_req),  32'h1);
      chk("p1_addr",  sram_addr,      32'(4 * i));
      chk("p1_pc_en", 32'(pc_enable), 32'h1);
      if (i == 0) chk("p1_first_valid", 32'(id_valid), 32'h0);
    end
    sample_pt();
    chk("p1_idle_pc_en", 32'(pc_enable), 32'h0);
    chk("p1_wait_addr",  sram_addr,      32'h18);
    drain("p1");

    // Ack delayed by 3 cycles
    apply_reset(3, 1, 1'b1);
    exp_push(32'h0);
    drive_pt();
    for (int i = 0; i < 3; i++) begin
      sample_pt();
      chk("p2_req",   32'(sram_req),  32'h1);
      chk("p2_addr",  sram_addr,      32'h0);
      chk("p2_pc_en", 32'(pc_enable), 32'h0);
    end
    sample_pt();
    chk("p2_ack_pc_en", 32'(pc_enable), 32'h1);
    chk("p2_ack_valid", 32'(id_valid),  32'h0);
    sample_pt();
    chk("p2_valid_next", 32'(id_valid), 32'h1);
    drain("p2");

    // Backpressure: queue fills, request drops, then drains in order
    apply_reset(0, 4, 1'b0);
    exp_push(32'h0);
    exp_push(32'h4);
    exp_push(32'h8);
    exp_push(32'hC);
    drive_pt();
    sample_pt();
    sample_pt();
    for (int i = 0; i < 3; i++) begin
      sample_pt();
      chk("p3_req_off",  32'(sram_req),  32'h0);
      chk("p3_pc_en",    32'(pc_enable), 32'h0);
      chk("p3_valid",    32'(id_valid),  32'h1);
      chk("p3_head_pc",  id_pc,          32'h0);
      chk("p3_head_ins", id_inst,        32'hA000_0000);
      chk("p3_pc_frozen", pc_q,          32'h8);
    end
    drive_pt();
    id_ready = 1'b1;
    sample_pt();
    chk("p3_still_idle", 32'(sram_req), 32'h0);
    sample_pt();
    chk("p3_resume_req",  32'(sram_req),  32'h1);
    chk("p3_resume_addr", sram_addr,      32'h8);
    chk("p3_resume_pcen", 32'(pc_enable), 32'h1);
    drain("p3");

    // Flush while the request at 0x8 is waiting
    apply_reset(0, 2, 1'b1);
    exp_push(32'h0);
    exp_push(32'h4);
    exp_push(32'h100);
    exp_push(32'h104);
    drive_pt();
    sample_pt();
    sample_pt();
    sample_pt();
    chk("p4_wait_addr",  sram_addr,      32'h8);
    chk("p4_wait_pc_en", 32'(pc_enable), 32'h0);
    drive_pt();
    flush    = 1'b1;
    redirect = 32'h100;
    sample_pt();
    chk("p4_flush_pc_en", 32'(pc_enable), 32'h0);
    chk("p4_flush_addr",  sram_addr,      32'h8);
    drive_pt();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample_pt();
      chk("p4_disc_req",   32'(sram_req),  32'h1);
      chk("p4_disc_addr",  sram_addr,      32'h8);
      chk("p4_disc_pc_en", 32'(pc_enable), 32'h0);
      chk("p4_disc_valid", 32'(id_valid),  32'h0);
    end
    drive_pt();
    ack_budget = 5;
    sample_pt();
    chk("p4_disc_ack",    32'(sram_ack),  32'h1);
    chk("p4_disc_ack_pe", 32'(pc_enable), 32'h0);
    chk("p4_disc_ack_ad", sram_addr,      32'h8);
    sample_pt();
    chk("p4_redir_addr",  sram_addr,      32'h100);
    chk("p4_redir_pc_en", 32'(pc_enable), 32'h1);
    drain("p4");

    // Flush coincident with the ack at 0x4
    apply_reset(0, 3, 1'b0);
    exp_push(32'h200);
    drive_pt();
    sample_pt();
    chk("p5_first_pc_en", 32'(pc_enable), 32'h1);
    drive_pt();
    flush    = 1'b1;
    redirect = 32'h200;
    sample_pt();
    chk("p5_ack_seen", 32'(sram_ack),  32'h1);
    chk("p5_addr",     sram_addr,      32'h4);
    chk("p5_pc_en",    32'(pc_enable), 32'h0);
    drive_pt();
    flush    = 1'b0;
    id_ready = 1'b1;
    sample_pt();
    chk("p5_empty",      32'(id_valid),  32'h0);
    chk("p5_redir_addr", sram_addr,      32'h200);
    chk("p5_redir_pcen", 32'(pc_enable), 32'h1);
    drain("p5");

    // Reset asserted in the middle of a request
    apply_reset(0, 2, 1'b0);
    drive_pt();
    sample_pt();
    sample_pt();
    chk("p6_pre_req",   32'(sram_req),  32'h1);
    chk("p6_pre_valid", 32'(id_valid),  32'h1);
    chk("p6_pre_pc_en", 32'(pc_enable), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("p6_rst_req",   32'(sram_req),  32'h0);
    chk("p6_rst_valid", 32'(id_valid),  32'h0);
    chk("p6_rst_pc_en", 32'(pc_enable), 32'h0);
    chk("p6_rst_id_pc", id_pc,          32'h0);
    repeat (2) @(posedge clk);
    ack_budget = 1;
    id_ready   = 1'b1;
    exp_push(32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("p6_idle_req", 32'(sram_req), 32'h0);
    drive_pt();
    sample_pt();
    chk("p6_req",  32'(sram_req), 32'h1);
    chk("p6_addr", sram_addr,     32'h0);
    drain("p6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
